// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame packer and its sample buffer.
package frame_pkg;

    localparam int         DEPTH_DEFAULT = 64;
    localparam logic [7:0] HDR0_DEFAULT  = 8'hEB;
    localparam logic [7:0] HDR1_DEFAULT  = 8'h90;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HDR0,
        ST_HDR1,
        ST_CHAN,
        ST_LEN,
        ST_PAY_HI,
        ST_PAY_LO,
        ST_CSUM
    } state_t;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_packer_if.sv
// Byte stream from the packer to the byte sink (valid/ready handshake).
interface frame_packer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/frame_packer_sample_buf.sv
// 16-bit simple dual-port sample RAM with a registered read port.
module sample_buf #(
    parameter int DEPTH = frame_pkg::DEPTH_DEFAULT,
    parameter int AW    = 6
) (
    input  logic          clk_25m,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    // Write port and registered read; a same-address collision returns the old word.
    always_ff @(posedge clk_25m) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_packer.sv
// Collects one data_flag burst into the sample buffer, then emits it as a
// framed byte stream: HDR0 HDR1 CHAN LEN {MSB LSB}*count CSUM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a data_flag rising edge
// COLLECT    | writing burst samples into the buffer
// HDR0       | first sync byte on tx_data
// HDR1       | second sync byte on tx_data
// CHAN       | latched channel byte on tx_data
// LEN        | sample count byte on tx_data
// PAY_HI     | MSB of current sample on tx_data
// PAY_LO     | LSB of current sample on tx_data
// CSUM       | checksum byte on tx_data
module frame_packer
    import frame_pkg::*;
#(
    parameter int         DEPTH = DEPTH_DEFAULT,
    parameter logic [7:0] HDR0  = HDR0_DEFAULT,
    parameter logic [7:0] HDR1  = HDR1_DEFAULT
) (
    input  logic           clk_25m,
    input  logic           rst,
    input  logic [15:0]    data_in,
    input  logic           data_flag,
    input  logic [3:0]     channel_number,
    frame_packer_if.master tx,
    output logic           frame_busy,
    output logic           overflow,
    output logic [7:0]     drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state_q, state_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic [CW-1:0] rd_idx_q, rd_idx_nxt;
    logic [3:0]    chan_q, chan_nxt;
    logic [7:0]    tx_data_q, tx_data_nxt;
    logic          tx_valid_q, tx_valid_nxt;
    logic [7:0]    csum_q, csum_nxt;
    logic          overflow_q, overflow_nxt;
    logic [7:0]    drop_q, drop_nxt;
    logic          flag_d_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   rd_data;
    logic          rise;
    logic          xfer;

    assign rise = data_flag && !flag_d_q;
    assign xfer = tx_valid_q && tx.tx_ready;

    // The read address follows the next index so rd_data already holds the
    // upcoming sample when the state that needs it is reached; this keeps
    // tx_valid free of bubbles across sample boundaries.
    sample_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_25m (clk_25m),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (rd_idx_nxt[AW-1:0]),
        .rd_data (rd_data)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_idx_q   <= '0;
            chan_q     <= 4'h0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            csum_q     <= 8'h00;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
            flag_d_q   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            count_q    <= count_nxt;
            rd_idx_q   <= rd_idx_nxt;
            chan_q     <= chan_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_valid_q <= tx_valid_nxt;
            csum_q     <= csum_nxt;
            overflow_q <= overflow_nxt;
            drop_q     <= drop_nxt;
            flag_d_q   <= data_flag;
        end
    end

    // Next-state, buffer write and output byte selection.
    always_comb begin
        state_nxt    = state_q;
        count_nxt    = count_q;
        rd_idx_nxt   = rd_idx_q;
        chan_nxt     = chan_q;
        tx_data_nxt  = tx_data_q;
        tx_valid_nxt = tx_valid_q;
        csum_nxt     = csum_q;
        overflow_nxt = overflow_q;
        drop_nxt     = drop_q;
        wr_en        = 1'b0;
        wr_addr      = count_q[AW-1:0];

        // Any burst that starts outside IDLE is dropped whole; it never
        // touches the buffer, so the frame in flight stays intact.
        if (rise && (state_q != ST_IDLE)) begin
            drop_nxt = sat_inc8(drop_q);
        end

        case (state_q)
            ST_IDLE: begin
                rd_idx_nxt = '0;
                if (rise) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    chan_nxt  = channel_number;
                    count_nxt = CW'(1);
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (data_flag) begin
                    if (count_q < CW'(DEPTH)) begin
                        wr_en     = 1'b1;
                        count_nxt = count_q + CW'(1);
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end else begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = HDR0;
                    csum_nxt     = 8'h00;
                    state_nxt    = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (xfer) begin
                    tx_data_nxt = HDR1;
                    state_nxt   = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (xfer) begin
                    tx_data_nxt = {4'h0, chan_q};
                    state_nxt   = ST_CHAN;
                end
            end
            ST_CHAN: begin
                if (xfer) begin
                    csum_nxt    = csum_q + tx_data_q;
                    tx_data_nxt = 8'(count_q);
                    state_nxt   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    csum_nxt    = csum_q + tx_data_q;
                    tx_data_nxt = rd_data[15:8];
                    state_nxt   = ST_PAY_HI;
                end
            end
            ST_PAY_HI: begin
                if (xfer) begin
                    csum_nxt    = csum_q + tx_data_q;
                    tx_data_nxt = rd_data[7:0];
                    rd_idx_nxt  = rd_idx_q + CW'(1);
                    state_nxt   = ST_PAY_LO;
                end
            end
            ST_PAY_LO: begin
                if (xfer) begin
                    csum_nxt = csum_q + tx_data_q;
                    if (rd_idx_q == count_q) begin
                        tx_data_nxt = csum_nxt;
                        state_nxt   = ST_CSUM;
                    end else begin
                        tx_data_nxt = rd_data[15:8];
                        state_nxt   = ST_PAY_HI;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    tx_valid_nxt = 1'b0;
                    count_nxt    = '0;
                    rd_idx_nxt   = '0;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign frame_busy  = (state_q != ST_IDLE);
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: framing, stalls, overflow, dropped bursts, reset abort.
module tb_frame_packer;
    import frame_pkg::*;

    logic        clk_25m = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        data_flag;
    logic [3:0]  channel_number;
    logic        frame_busy;
    logic        overflow;
    logic [7:0]  drop_cnt;

    frame_packer_if bus ();

    frame_packer dut (
        .clk_25m        (clk_25m),
        .rst            (rst),
        .data_in        (data_in),
        .data_flag      (data_flag),
        .channel_number (channel_number),
        .tx             (bus),
        .frame_busy     (frame_busy),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #20 clk_25m = ~clk_25m;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] smp_q[$];
    int          inj_left = 0;

    task automatic step();
        @(posedge clk_25m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame from the sample list, capped at 64 samples.
    function automatic void build(input logic [3:0] ch, input int n);
        logic [7:0] s;
        int m;
        m = (n > 64) ? 64 : n;
        exp_q.delete();
        exp_q.push_back(8'hEB);
        exp_q.push_back(8'h90);
        exp_q.push_back({4'h0, ch});
        exp_q.push_back(8'(m));
        s = {4'h0, ch} + 8'(m);
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(smp_q[i][15:8]);
            exp_q.push_back(smp_q[i][7:0]);
            s = s + smp_q[i][15:8] + smp_q[i][7:0];
        end
        exp_q.push_back(s);
    endfunction

    task automatic send_burst(input logic [3:0] ch_a, input logic [3:0] ch_b, input int sw);
        for (int i = 0; i < smp_q.size(); i++) begin
            data_flag      = 1'b1;
            data_in        = smp_q[i];
            channel_number = (i < sw) ? ch_a : ch_b;
            step();
        end
        data_flag      = 1'b0;
        channel_number = 4'hF;
        step();
    endtask

    task automatic inj_tick();
        if (inj_left > 0) begin
            data_flag      = 1'b1;
            data_in        = 16'hDEAD;
            channel_number = 4'h2;
            inj_left--;
        end else begin
            data_flag = 1'b0;
        end
    endtask

    // Receive exp_q; optionally stall every other cycle and start an
    // interfering burst when byte inj_at is on the bus.
    task automatic recv(input string tag, input bit alt, input int inj_at, input int inj_len);
        int  waitc = 0;
        int  idx   = 0;
        int  guard = 0;
        bit  rdy   = 1'b0;
        bit  injd  = 1'b0;
        int  n     = exp_q.size();
        while (bus.tx_valid !== 1'b1 && waitc < 40) begin
            step();
            waitc++;
        end
        chk($sformatf("%s_start", tag), {31'd0, bus.tx_valid}, 1);
        while (idx < n && guard < 400) begin
            chk($sformatf("%s_valid%0d", tag, idx), {31'd0, bus.tx_valid}, 1);
            chk($sformatf("%s_byte%0d", tag, idx), {24'd0, bus.tx_data}, {24'd0, exp_q[idx]});
            if (idx == inj_at && !injd) begin
                inj_left = inj_len;
                injd     = 1'b1;
            end
            rdy = alt ? ~rdy : 1'b1;
            bus.tx_ready = rdy;
            inj_tick();
            if (rdy) idx++;
            step();
            guard++;
        end
        chk($sformatf("%s_done", tag), idx, n);
        chk($sformatf("%s_valid_end", tag), {31'd0, bus.tx_valid}, 0);
        chk($sformatf("%s_busy_end", tag), {31'd0, frame_busy}, 0);
        while (inj_left > 0) begin
            inj_tick();
            step();
        end
        data_flag    = 1'b0;
        bus.tx_ready = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        data_flag      = 1'b0;
        data_in        = 16'h0000;
        channel_number = 4'h0;
        bus.tx_ready   = 1'b1;
        step();
        step();
        chk("rst_valid", {31'd0, bus.tx_valid}, 0);
        chk("rst_data", {24'd0, bus.tx_data}, 0);
        chk("rst_busy", {31'd0, frame_busy}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_drop", {24'd0, drop_cnt}, 0);
        rst = 1'b0;
        step();

        // Basic 3-sample frame, sink always ready.
        smp_q = {16'h1234, 16'hABCD, 16'h0001};
        send_burst(4'h1, 4'h1, 99);
        exp_q = {8'hEB, 8'h90, 8'h01, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC3};
        recv("basic", 1'b0, -1, 0);

        // Same frame with the sink stalling every other cycle.
        send_burst(4'h1, 4'h1, 99);
        recv("stall", 1'b1, -1, 0);

        // Channel changes mid-burst; the first channel is kept.
        smp_q = {16'h0102, 16'h0304};
        send_burst(4'h1, 4'h2, 1);
        exp_q = {8'hEB, 8'h90, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0D};
        recv("chsw", 1'b0, -1, 0);

        // Burst arriving during PAY_LO is dropped; the frame stays intact.
        smp_q = {16'h1234, 16'hABCD, 16'h0001};
        send_burst(4'h1, 4'h1, 99);
        exp_q = {8'hEB, 8'h90, 8'h01, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC3};
        recv("drop1", 1'b0, 5, 2);
        chk("drop1_cnt", {24'd0, drop_cnt}, 1);
        smp_q = {16'h5A5A};
        send_burst(4'h4, 4'h4, 99);
        exp_q = {8'hEB, 8'h90, 8'h04, 8'h01, 8'h5A, 8'h5A, 8'hB9};
        recv("after_drop", 1'b0, -1, 0);

        // Rising edge on the CSUM transfer cycle is dropped, and the tail of
        // that burst in IDLE must not start a frame.
        smp_q = {16'h0010};
        send_burst(4'h5, 4'h5, 99);
        exp_q = {8'hEB, 8'h90, 8'h05, 8'h01, 8'h00, 8'h10, 8'h16};
        recv("csum_edge", 1'b0, 6, 3);
        chk("csum_edge_cnt", {24'd0, drop_cnt}, 2);
        for (int i = 0; i < 4; i++) step();
        chk("csum_edge_idle_busy", {31'd0, frame_busy}, 0);
        chk("csum_edge_idle_valid", {31'd0, bus.tx_valid}, 0);

        // 70-sample burst: only the first 64 are framed, overflow sticks.
        chk("ovf_before", {31'd0, overflow}, 0);
        smp_q.delete();
        for (int i = 0; i < 70; i++) smp_q.push_back(16'(i));
        send_burst(4'h6, 4'h6, 99);
        chk("ovf_set", {31'd0, overflow}, 1);
        build(4'h6, 70);
        chk("ovf_len_model", {24'd0, exp_q[3]}, 32'h40);
        recv("ovf", 1'b0, -1, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);
        chk("ovf_drop", {24'd0, drop_cnt}, 2);

        // Frame parked at PAY_HI: drop counter increments then saturates.
        smp_q = {16'h1111, 16'h2222};
        send_burst(4'h7, 4'h7, 99);
        exp_q = {8'hEB, 8'h90, 8'h07, 8'h02, 8'h11};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("abort_byte%0d", i), {24'd0, bus.tx_data}, {24'd0, exp_q[i]});
            if (i < 4) begin
                bus.tx_ready = 1'b1;
                step();
            end
        end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            data_flag = 1'b1;
            step();
            data_flag = 1'b0;
            step();
        end
        chk("drop_count_100", {24'd0, drop_cnt}, 102);
        for (int i = 0; i < 160; i++) begin
            data_flag = 1'b1;
            step();
            data_flag = 1'b0;
            step();
        end
        chk("drop_sat", {24'd0, drop_cnt}, 255);
        chk("park_data", {24'd0, bus.tx_data}, 32'h11);
        chk("park_valid", {31'd0, bus.tx_valid}, 1);

        // Reset while in PAY_HI aborts the frame.
        rst = 1'b1;
        step();
        chk("abort_valid", {31'd0, bus.tx_valid}, 0);
        chk("abort_data", {24'd0, bus.tx_data}, 0);
        chk("abort_busy", {31'd0, frame_busy}, 0);
        chk("abort_drop", {24'd0, drop_cnt}, 0);
        chk("abort_ovf", {31'd0, overflow}, 0);
        rst          = 1'b0;
        bus.tx_ready = 1'b1;
        step();
        smp_q = {16'h00FF};
        send_burst(4'h3, 4'h3, 99);
        exp_q = {8'hEB, 8'h90, 8'h03, 8'h01, 8'h00, 8'hFF, 8'h03};
        recv("post_rst", 1'b0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
